// File: rtl/drop_tick_gen.sv
// rtl/drop_tick_gen.sv - gravity / soft-drop request generator with overrun counting
//
// Ports:
//   clk_20MHz   in   only clock, rising edge
//   rst         in   synchronous active-high reset
//   clk_1Hz     in   slow toggle, asynchronous; every edge is a half-tick
//   enable      in   game running; low forces IDLE
//   level[2:0]  in   gravity level; interval = 8 - level half-ticks
//   soft_drop   in   player holding down; SOFT_DIV-cycle prescaler
//   drop_ack    in   game logic consumed the pending request
//   drop_req    out  registered request, held until acknowledged
//   drop_src    out  0 = gravity, 1 = soft drop (valid with drop_req)
//   overrun_cnt out  saturating count of half-ticks lost while pending
module drop_tick_gen #(
    parameter int unsigned SOFT_DIV = 1000000
) (
    input  logic       clk_20MHz,
    input  logic       rst,
    input  logic       clk_1Hz,
    input  logic       enable,
    input  logic [2:0] level,
    input  logic       soft_drop,
    input  logic       drop_ack,
    output logic       drop_req,
    output logic       drop_src,
    output logic [7:0] overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        REQ   = 2'd2
    } state_t;

    localparam logic [19:0] SOFT_LAST = 20'(SOFT_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_cur;
    logic        r_prev;
    logic        r_half_tick;

    logic [19:0] r_soft_cnt;
    logic        w_soft_tick;

    logic [3:0]  r_interval;
    logic [3:0]  w_interval_next;
    logic [3:0]  w_reload;

    logic        r_drop_req;
    logic        r_drop_src;
    logic        w_src_next;
    logic [7:0]  r_overrun;
    logic [7:0]  w_overrun_next;

    // Two synchronizer flops, then a registered copy of the synchronized level
    // and its previous value; the edge pulse is registered so half_tick is a
    // clean one-cycle strobe three edges after the first sampling edge.
    always_ff @(posedge clk_20MHz) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_cur       <= 1'b0;
            r_prev      <= 1'b0;
            r_half_tick <= 1'b0;
        end else begin
            r_sync1     <= clk_1Hz;
            r_sync2     <= r_sync1;
            r_cur       <= r_sync2;
            r_prev      <= r_cur;
            r_half_tick <= r_cur ^ r_prev;
        end
    end

    // Prescaler is held at zero while soft_drop is low, so the first tick
    // lands exactly SOFT_DIV cycles after the button is pressed.
    assign w_soft_tick = soft_drop && (r_soft_cnt == SOFT_LAST);

    always_ff @(posedge clk_20MHz) begin
        if (rst || !soft_drop) begin
            r_soft_cnt <= 20'd0;
        end else if (w_soft_tick) begin
            r_soft_cnt <= 20'd0;
        end else begin
            r_soft_cnt <= r_soft_cnt + 20'd1;
        end
    end

    assign w_reload = 4'd8 - {1'b0, level};

    always_comb begin
        w_state_next    = r_state;
        w_interval_next = r_interval;
        w_src_next      = r_drop_src;
        w_overrun_next  = r_overrun;

        if (!enable) begin
            w_state_next    = IDLE;
            w_interval_next = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next    = COUNT;
                    w_interval_next = w_reload;
                end
                COUNT: begin
                    // Soft drop outranks a gravity expiry in the same cycle.
                    if (w_soft_tick) begin
                        w_state_next = REQ;
                        w_src_next   = 1'b1;
                    end else if (r_half_tick) begin
                        if (r_interval <= 4'd1) begin
                            w_state_next = REQ;
                            w_src_next   = 1'b0;
                        end else begin
                            w_interval_next = r_interval - 4'd1;
                        end
                    end
                end
                REQ: begin
                    // A half-tick arriving with the ack is dropped entirely:
                    // not an overrun, and not charged to the fresh interval.
                    if (drop_ack) begin
                        w_state_next    = COUNT;
                        w_interval_next = w_reload;
                    end else if (r_half_tick && (r_overrun != 8'hFF)) begin
                        w_overrun_next = r_overrun + 8'd1;
                    end
                end
                default: begin
                    w_state_next    = IDLE;
                    w_interval_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_20MHz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_interval <= 4'd0;
            r_drop_req <= 1'b0;
            r_drop_src <= 1'b0;
            r_overrun  <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_interval <= w_interval_next;
            r_drop_req <= (w_state_next == REQ);
            r_drop_src <= w_src_next;
            r_overrun  <= w_overrun_next;
        end
    end

    assign drop_req    = r_drop_req;
    assign drop_src    = r_drop_src;
    assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_drop_tick_gen.sv
// tb/tb_drop_tick_gen.sv - scoreboard bench for drop_tick_gen (SOFT_DIV=10)
module tb_drop_tick_gen;

    typedef struct {
        int src;
        int ovr;
        int cyc;
    } exp_t;

    logic       clk_20MHz = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1Hz = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] level = 3'd0;
    logic       soft_drop = 1'b0;
    logic       ack_man = 1'b0;
    logic       ack_auto = 1'b0;
    logic       auto_ack = 1'b0;
    wire        drop_ack = ack_auto | ack_man;
    logic       drop_req;
    logic       drop_src;
    logic [7:0] overrun_cnt;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_req = 1'b0;
    exp_t exp_q[$];

    drop_tick_gen #(.SOFT_DIV(10)) dut (
        .clk_20MHz   (clk_20MHz),
        .rst         (rst),
        .clk_1Hz     (clk_1Hz),
        .enable      (enable),
        .level       (level),
        .soft_drop   (soft_drop),
        .drop_ack    (drop_ack),
        .drop_req    (drop_req),
        .drop_src    (drop_src),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk_20MHz = ~clk_20MHz;

    always @(posedge clk_20MHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_20MHz);
            #1;
        end
    endtask

    task automatic push(input int src, input int ovr, input int at);
        exp_t e;
        e.src = src;
        e.ovr = ovr;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic toggle();
        clk_1Hz = ~clk_1Hz;
    endtask

    // Acknowledge one cycle after a request appears.
    always @(posedge clk_20MHz) begin
        #1;
        ack_auto = auto_ack && drop_req && !ack_auto;
    end

    // Monitor: every rising drop_req must match the next queued expectation.
    always @(negedge clk_20MHz) begin
        exp_t e;
        if (drop_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_src", 32'(drop_src), 32'(e.src));
                check("req_overrun", 32'(overrun_cnt), 32'(e.ovr));
                check("req_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_req = drop_req;
    end

    initial begin
        int s;
        // Reset state
        step(3);
        check("rst_req", 32'(drop_req), 32'd0);
        check("rst_src", 32'(drop_src), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);

        // Level 7: every half-tick raises a gravity request
        rst = 1'b0;
        enable = 1'b1;
        level = 3'd7;
        auto_ack = 1'b1;
        step(5);
        for (int i = 0; i < 4; i++) begin
            toggle();
            push(0, 0, cyc + 5);
            step(50);
        end

        // Level 0: interval of 8; mid-count change to 7 only affects next load
        level = 3'd0;
        toggle();
        push(0, 0, cyc + 5);
        step(20);
        for (int i = 1; i <= 8; i++) begin
            toggle();
            if (i == 8) push(0, 0, cyc + 5);
            if (i == 3) level = 3'd7;
            step(20);
        end
        toggle();
        push(0, 0, cyc + 5);
        step(20);

        // Soft drop: ticks every 10 cycles, release clears prescaler
        level = 3'd0;
        soft_drop = 1'b1;
        s = cyc;
        push(1, 0, s + 10);
        push(1, 0, s + 20);
        push(1, 0, s + 30);
        step(34);
        soft_drop = 1'b0;
        step(3);
        soft_drop = 1'b1;
        push(1, 0, cyc + 10);
        step(12);
        soft_drop = 1'b0;
        step(5);

        // Soft tick coincident with gravity expiry: one request, src=1
        level = 3'd7;
        soft_drop = 1'b1;
        s = cyc;
        push(1, 0, s + 10);
        push(1, 0, s + 20);
        step(15);
        toggle();
        step(7);
        soft_drop = 1'b0;
        step(10);

        // Overrun: no ack, half-ticks accumulate and saturate
        auto_ack = 1'b0;
        toggle();
        push(0, 0, cyc + 5);
        step(6);
        for (int i = 0; i < 10; i++) begin
            toggle();
            step(4);
        end
        step(8);
        check("ovr_10", 32'(overrun_cnt), 32'd10);
        check("ovr_req_held", 32'(drop_req), 32'd1);
        toggle();
        step(4);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        check("coinc_ack_req", 32'(drop_req), 32'd0);
        check("coinc_ack_ovr", 32'(overrun_cnt), 32'd10);
        step(10);
        toggle();
        push(0, 10, cyc + 5);
        step(6);
        for (int i = 0; i < 300; i++) begin
            toggle();
            step(4);
        end
        step(8);
        check("ovr_sat", 32'(overrun_cnt), 32'd255);
        check("sat_req_held", 32'(drop_req), 32'd1);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        step(3);

        // Disable while in REQ, then reset while in COUNT
        toggle();
        push(0, 255, cyc + 5);
        step(6);
        enable = 1'b0;
        step(1);
        check("dis_req", 32'(drop_req), 32'd0);
        check("dis_ovr", 32'(overrun_cnt), 32'd255);
        enable = 1'b1;
        step(3);
        rst = 1'b1;
        clk_1Hz = 1'b1;
        step(1);
        check("rst_cnt_req", 32'(drop_req), 32'd0);
        check("rst_cnt_ovr", 32'(overrun_cnt), 32'd0);
        check("rst_cnt_src", 32'(drop_src), 32'd0);
        step(2);

        // Release with clk_1Hz high: first sample counts as an edge
        rst = 1'b0;
        push(0, 0, cyc + 5);
        step(7);
        check("post_rst_req", 32'(drop_req), 32'd1);
        rst = 1'b1;
        step(1);
        check("rst_in_req", 32'(drop_req), 32'd0);
        rst = 1'b0;
        step(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
